// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset CPU core.
// A six-state FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) shares one req/ready memory
// port between instruction fetch and load/store, so wait-state memories work.
// Memory-port and status outputs are decoded from registered state and
// registers only, so no input reaches an output combinationally.
module multicycle_cpu #(
    parameter int          N        = 32,
    parameter int          REG_AW   = 5,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic [N-1:0] pc,
    output logic [31:0]  instr,
    output logic [2:0]   state,
    output logic         illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_ORI   = 6'b001101,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        F_ADD = 6'b100000,
        F_SUB = 6'b100010,
        F_AND = 6'b100100,
        F_OR  = 6'b100101,
        F_SLT = 6'b101010
    } func_t;

    state_t           st;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [N-1:0]     alu_out;
    logic [N-1:0]     mdr;
    logic [N-1:0]     target;
    logic [N-1:0]     regs [2**REG_AW];

    // Instruction fields; register indices use the low REG_AW bits.
    logic [5:0]        op;
    logic [5:0]        func;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm16;
    logic [N-1:0]      sext_imm;
    logic [N-1:0]      zext_imm;
    logic [N-1:0]      rs_val;
    logic [N-1:0]      rt_val;

    assign op       = instr[31:26];
    assign func     = instr[5:0];
    assign rs       = instr[21 +: REG_AW];
    assign rt       = instr[16 +: REG_AW];
    assign rd       = instr[11 +: REG_AW];
    assign imm16    = instr[15:0];
    assign sext_imm = {{(N-16){imm16[15]}}, imm16};
    assign zext_imm = {{(N-16){1'b0}}, imm16};

    // Register 0 always reads as zero regardless of array contents.
    assign rs_val = (rs == '0) ? '0 : regs[rs];
    assign rt_val = (rt == '0) ? '0 : regs[rt];

    assign state = st;

    logic              legal;
    logic [N-1:0]      r_result;
    logic [REG_AW-1:0] wb_idx;
    logic [N-1:0]      wb_data;

    // Opcode/function legality check used in DECODE.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = func inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    // R-type ALU; slt compares as two's-complement.
    always_comb begin
        r_result = '0;
        case (func)
            F_ADD:   r_result = a + b;
            F_SUB:   r_result = a - b;
            F_AND:   r_result = a & b;
            F_OR:    r_result = a | b;
            F_SLT:   r_result = N'($signed(a) < $signed(b));
            default: r_result = '0;
        endcase
    end

    // Write-back destination: rd for R-type, rt otherwise; loads write MDR.
    always_comb begin
        wb_idx  = rt;
        wb_data = alu_out;
        if (op == OP_RTYPE) wb_idx = rd;
        if (op == OP_LW)    wb_data = mdr;
    end

    // Memory port: fetch uses pc, MEM uses the computed address; held stable per state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        case (st)
            S_FETCH: mem_req = 1'b1;
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_out;
                if (op == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = b;
                end
            end
            default: ;
        endcase
    end

    assign illegal = (st == S_DECODE) && !legal;

    // Main FSM and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            st      <= S_IDLE;
            pc      <= PC_RESET;
            instr   <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            target  <= '0;
            // NOTE: the register file is cleared on reset, which rules out a plain RAM macro for it.
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            case (st)
                S_IDLE: st <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        instr <= mem_rdata[31:0];
                        pc    <= pc + N'(4);
                        st    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= rs_val;
                    b      <= rt_val;
                    target <= pc + (sext_imm << 2);
                    st     <= legal ? S_EXEC : S_FETCH;
                end
                S_EXEC: begin
                    case (op)
                        OP_RTYPE: begin alu_out <= r_result;     st <= S_WB;  end
                        OP_ADDI:  begin alu_out <= a + sext_imm; st <= S_WB;  end
                        OP_ORI:   begin alu_out <= a | zext_imm; st <= S_WB;  end
                        OP_LW,
                        OP_SW:    begin alu_out <= a + sext_imm; st <= S_MEM; end
                        OP_BEQ: begin
                            if (a == b) pc <= target;
                            st <= S_FETCH;
                        end
                        OP_J: begin
                            pc <= {pc[N-1:28], instr[25:0], 2'b00};
                            st <= S_FETCH;
                        end
                        default: st <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_LW) begin
                            mdr <= mem_rdata;
                            st  <= S_WB;
                        end else begin
                            st <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx != '0) regs[wb_idx] <= wb_data;
                    st <= S_FETCH;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: wait-state memory model, table-driven
// per-instruction checks (cycles, next pc, stores, illegal pulse) and
// hand-written reset sequences.
module tb_multicycle_cpu;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [N-1:0] pc;
    logic [31:0]  instr;
    logic [2:0]   state;
    logic         illegal;

    multicycle_cpu #(.N(N), .REG_AW(5), .PC_RESET(32'h100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .instr     (instr),
        .state     (state),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- memory model ----------------
    logic [31:0] prog [256];
    logic [31:0] dmem [256];
    int          dgen [256];
    int          gen = 1;
    int          wait_cycles = 0;
    logic        block_writes = 1'b0;
    int          cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    int          wr_count = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    int          unstable = 0;

    // Memory responds at the falling edge; a transfer completed at the previous rising edge
    // when req and ready were both high with reset released.
    always @(negedge clk) begin
        logic       done;
        logic [7:0] idx;
        done = (rst_n === 1'b1) && (prev_req === 1'b1) && (prev_ready === 1'b1);
        if (done && prev_we) begin
            dmem[prev_addr[9:2]] = prev_wdata;
            dgen[prev_addr[9:2]] = gen;
            wr_count++;
            wr_addr = prev_addr;
            wr_data = prev_wdata;
        end
        if ((rst_n === 1'b1) && (prev_req === 1'b1) && (prev_ready === 1'b0) && (mem_req === 1'b1)) begin
            if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) unstable++;
        end
        if (done || mem_req !== 1'b1) cnt = 0;
        if (mem_req === 1'b1) begin
            if (block_writes && mem_we) begin
                mem_ready = 1'b0;
            end else if (cnt >= wait_cycles) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                cnt++;
            end
            idx = mem_addr[9:2];
            mem_rdata = (dgen[idx] == gen) ? dmem[idx] : prog[idx];
        end else begin
            mem_ready = 1'b0;
        end
        prev_req   = mem_req;
        prev_ready = mem_ready;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    // ---------------- encoders and vectors ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] func);
        return {6'h00, rs, rt, rd, 5'h00, func};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        int          cycles;
        logic [31:0] next_pc;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        ill;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] ins, input int cyc,
                                input logic [31:0] npc, input logic wr, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic ill);
        vec_t v;
        v.addr = addr; v.ins = ins; v.cycles = cyc; v.next_pc = npc;
        v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.ill = ill;
        return v;
    endfunction

    // Run one instruction from the first cycle of its FETCH to the first cycle of the next FETCH.
    task automatic step(input string tag, input vec_t v);
        int         cyc;
        int         ill;
        int         wr0;
        logic [2:0] prev;
        logic       done;
        wr0  = wr_count;
        cyc  = 0;
        ill  = 0;
        prev = state;
        done = 1'b0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (illegal === 1'b1) ill++;
            if (state == 3'd1 && prev != 3'd1) done = 1'b1;
            prev = state;
        end
        check({tag, " cycles"}, cyc, v.cycles);
        check({tag, " next_pc"}, pc, v.next_pc);
        check({tag, " illegal_pulses"}, ill, {31'b0, v.ill});
        check({tag, " writes"}, wr_count - wr0, {31'b0, v.wr});
        if (v.wr && wr_count != wr0) begin
            check({tag, " waddr"}, wr_addr, v.waddr);
            check({tag, " wdata"}, wr_data, v.wdata);
        end
    endtask

    vec_t main_v [23];
    vec_t mem_v  [4];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        main_v[0]  = mk(32'h100, enc_i(6'h08, 0, 1, 16'h0005), 4, 32'h104, 0, 0, 0, 0);
        main_v[1]  = mk(32'h104, enc_i(6'h08, 0, 2, 16'hFFFD), 4, 32'h108, 0, 0, 0, 0);
        main_v[2]  = mk(32'h108, enc_r(1, 2, 3, 6'h20), 4, 32'h10C, 0, 0, 0, 0);
        main_v[3]  = mk(32'h10C, enc_r(2, 1, 4, 6'h22), 4, 32'h110, 0, 0, 0, 0);
        main_v[4]  = mk(32'h110, enc_r(2, 1, 5, 6'h2A), 4, 32'h114, 0, 0, 0, 0);
        main_v[5]  = mk(32'h114, enc_i(6'h0D, 0, 6, 16'hFFFF), 4, 32'h118, 0, 0, 0, 0);
        main_v[6]  = mk(32'h118, enc_i(6'h2B, 0, 3, 16'h0200), 4, 32'h11C, 1, 32'h200, 32'h2, 0);
        main_v[7]  = mk(32'h11C, enc_i(6'h2B, 0, 4, 16'h0204), 4, 32'h120, 1, 32'h204, 32'hFFFFFFF8, 0);
        main_v[8]  = mk(32'h120, enc_i(6'h2B, 0, 5, 16'h0208), 4, 32'h124, 1, 32'h208, 32'h1, 0);
        main_v[9]  = mk(32'h124, enc_i(6'h2B, 0, 6, 16'h020C), 4, 32'h128, 1, 32'h20C, 32'h0000FFFF, 0);
        main_v[10] = mk(32'h128, enc_i(6'h04, 1, 1, 16'h0002), 3, 32'h134, 0, 0, 0, 0);
        main_v[11] = mk(32'h134, enc_i(6'h04, 1, 2, 16'h0005), 3, 32'h138, 0, 0, 0, 0);
        main_v[12] = mk(32'h138, enc_i(6'h08, 0, 0, 16'h0007), 4, 32'h13C, 0, 0, 0, 0);
        main_v[13] = mk(32'h13C, enc_i(6'h2B, 0, 0, 16'h0210), 4, 32'h140, 1, 32'h210, 32'h0, 0);
        main_v[14] = mk(32'h140, 32'hFC000000, 2, 32'h144, 0, 0, 0, 1);
        main_v[15] = mk(32'h144, enc_i(6'h2B, 0, 1, 16'h0214), 4, 32'h148, 1, 32'h214, 32'h5, 0);
        main_v[16] = mk(32'h148, enc_r(4, 6, 8, 6'h24), 4, 32'h14C, 0, 0, 0, 0);
        main_v[17] = mk(32'h14C, enc_r(1, 4, 9, 6'h25), 4, 32'h150, 0, 0, 0, 0);
        main_v[18] = mk(32'h150, enc_i(6'h2B, 0, 8, 16'h0218), 4, 32'h154, 1, 32'h218, 32'h0000FFF8, 0);
        main_v[19] = mk(32'h154, enc_i(6'h2B, 0, 9, 16'h021C), 4, 32'h158, 1, 32'h21C, 32'hFFFFFFFD, 0);
        main_v[20] = mk(32'h158, enc_r(1, 2, 10, 6'h00), 2, 32'h15C, 0, 0, 0, 1);
        main_v[21] = mk(32'h15C, enc_i(6'h2B, 0, 10, 16'h0220), 4, 32'h160, 1, 32'h220, 32'h0, 0);
        main_v[22] = mk(32'h160, enc_j(26'h40), 3, 32'h100, 0, 0, 0, 0);

        mem_v[0] = mk(32'h100, enc_i(6'h08, 0, 1, 16'h0005), 7, 32'h104, 0, 0, 0, 0);
        mem_v[1] = mk(32'h104, enc_i(6'h2B, 0, 1, 16'h0008), 10, 32'h108, 1, 32'h8, 32'h5, 0);
        mem_v[2] = mk(32'h108, enc_i(6'h23, 0, 7, 16'h0008), 11, 32'h10C, 0, 0, 0, 0);
        mem_v[3] = mk(32'h10C, enc_i(6'h2B, 0, 7, 16'h000C), 10, 32'h110, 1, 32'hC, 32'h5, 0);

        // ---- T1: reset held two cycles ----
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        for (int i = 0; i < 23; i++) prog[main_v[i].addr[9:2]] = main_v[i].ins;
        prog[32'h12C >> 2] = enc_i(6'h08, 0, 1, 16'd99);
        prog[32'h130 >> 2] = enc_i(6'h08, 0, 1, 16'd99);
        tick();
        tick();
        check("reset pc", pc, 32'h100);
        check("reset state", {29'b0, state}, 32'd0);
        check("reset mem_req", {31'b0, mem_req}, 32'd0);
        check("reset mem_we", {31'b0, mem_we}, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset mem_addr", mem_addr, 32'h100);
        check("reset illegal", {31'b0, illegal}, 32'd0);
        check("reset instr", instr, 32'd0);
        rst_n = 1'b1;
        tick();
        check("first fetch state", {29'b0, state}, 32'd1);
        check("first fetch req", {31'b0, mem_req}, 32'd1);
        check("first fetch addr", mem_addr, 32'h100);

        // ---- T2/T4/T5: ALU, control flow, illegal at zero wait ----
        for (int i = 0; i < 23; i++) step($sformatf("main%0d", i), main_v[i]);

        // ---- T3: store then load with 3 wait cycles per access ----
        rst_n = 1'b0;
        tick();
        gen++;
        wait_cycles = 3;
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        for (int i = 0; i < 4; i++) prog[mem_v[i].addr[9:2]] = mem_v[i].ins;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) step($sformatf("wait%0d", i), mem_v[i]);

        // ---- T6: reset while a store waits in MEM ----
        rst_n = 1'b0;
        tick();
        gen++;
        wait_cycles = 0;
        block_writes = 1'b1;
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        prog[32'h100 >> 2] = enc_i(6'h08, 0, 1, 16'd9);
        prog[32'h104 >> 2] = enc_i(6'h2B, 0, 1, 16'h0030);
        tick();
        rst_n = 1'b1;
        tick();
        step("t6 addi", mk(32'h100, prog[32'h100 >> 2], 4, 32'h104, 0, 0, 0, 0));
        k = 0;
        while (state != 3'd4 && k < 10) begin
            tick();
            k++;
        end
        tick();
        tick();
        tick();
        check("t6 stuck state", {29'b0, state}, 32'd4);
        check("t6 stuck req", {31'b0, mem_req}, 32'd1);
        check("t6 stuck we", {31'b0, mem_we}, 32'd1);
        check("t6 stuck addr", mem_addr, 32'h30);
        check("t6 stuck wdata", mem_wdata, 32'd9);
        k = wr_count;
        rst_n = 1'b0;
        tick();
        check("t6 req after reset", {31'b0, mem_req}, 32'd0);
        check("t6 state after reset", {29'b0, state}, 32'd0);
        check("t6 pc after reset", pc, 32'h100);
        check("t6 no write", wr_count - k, 32'd0);
        rst_n = 1'b1;
        block_writes = 1'b0;
        tick();
        check("t6 restart state", {29'b0, state}, 32'd1);
        check("t6 restart addr", mem_addr, 32'h100);
        step("t6 rerun addi", mk(32'h100, prog[32'h100 >> 2], 4, 32'h104, 0, 0, 0, 0));

        check("handshake stability violations", unstable, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
